// File: rtl/tx_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_uart
// Purpose  : 8N1 serial transmitter, LSB first, idle-high line. One frame is
//            START, DATA (8 bits), optional PARITY, STOP; each bit lasts
//            DIV = CLK_HZ/BPS clock cycles. All outputs are registered.
// Options  : define TX_UART_PARITY_EN to insert an even-parity bit between
//            the last data bit and the stop bit (frame grows to 11*DIV).
// Revision : 1.0 - initial release
// ============================================================================
module tx_uart #(
   parameter int CLK_HZ = 50000000,
   parameter int BPS    = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_enable_signal,
   input  logic [7:0] tx_data,
   output logic       tx_out,
   output logic       tx_busy,
   output logic       tx_done_signal
);

   // Clock cycles per bit and the width of the bit-period counter.
   localparam int DIV   = CLK_HZ / BPS;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   // Last count of a bit period and the count just before it.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

   localparam logic [2:0] LAST_IDX = 3'd7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef TX_UART_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [2:0]       idx_q,    idx_d;
   logic [7:0]       data_q,   data_d;
   logic             tx_out_q, tx_out_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   logic             bit_end;

   // A bit period ends when the counter has reached its last value.
   assign bit_end = (cnt_q == CNT_LAST);

   // Next-state logic: the line level of the coming cycle is computed here so
   // the output flop carries the new bit exactly at the bit boundary.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      data_d   = data_q;
      tx_out_d = tx_out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
            cnt_d    = '0;
            idx_d    = '0;
            if (tx_enable_signal) begin
               // Byte is captured here; later tx_data changes cannot leak in.
               data_d   = tx_data;
               state_d  = START;
               tx_out_d = 1'b0;
               busy_d   = 1'b1;
            end
         end

         START: begin
            if (bit_end) begin
               cnt_d    = '0;
               idx_d    = '0;
               state_d  = DATA;
               tx_out_d = data_q[0];
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == LAST_IDX) begin
`ifdef TX_UART_PARITY_EN
                  state_d  = PARITY;
                  tx_out_d = ^data_q;
`else
                  state_d  = STOP;
                  tx_out_d = 1'b1;
`endif
               end else begin
                  idx_d    = idx_q + 3'd1;
                  tx_out_d = data_q[idx_d];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

`ifdef TX_UART_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               cnt_d    = '0;
               state_d  = STOP;
               tx_out_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif

         STOP: begin
            tx_out_d = 1'b1;
            if (bit_end) begin
               cnt_d   = '0;
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               // Registered pulse lands on the final stop-bit cycle.
               if (cnt_q == CNT_PRE) begin
                  done_d = 1'b1;
               end
            end
         end

         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         tx_out_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         tx_out_q <= tx_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign tx_out         = tx_out_q;
   assign tx_busy        = busy_q;
   assign tx_done_signal = done_q;

endmodule
`default_nettype wire

// File: doc/tx_uart.md
TX_UART -- requirements
Module: tx_uart

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BPS, default 1000000, line bit rate in bit/s.
REQ-003 SHALL derive local constant DIV = CLK_HZ/BPS (integer truncation) as clock cycles per bit; default 50.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port tx_enable_signal  input  1  send request, sampled only in IDLE.
REQ-007 SHALL have port tx_data  input  8  byte to send, captured on the accepted request.
REQ-008 SHALL have port tx_out  output  1  serial line, idle high.
REQ-009 SHALL have port tx_busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.
REQ-010 SHALL have port tx_done_signal  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (macro-dependent), STOP.
REQ-012 IDLE: tx_out=1, tx_busy=0; on tx_enable_signal=1, latch tx_data into shift register and go to START next cycle.
REQ-013 START: tx_out=0 for exactly DIV cycles, then DATA.
REQ-014 DATA: 8 bits, LSB first, each held DIV cycles; 3-bit index counts 0..7, then PARITY if enabled, else STOP.
REQ-015 STOP: tx_out=1 for DIV cycles; tx_done_signal=1 in the final STOP cycle only; next cycle IDLE.
REQ-016 Bit-period counter: width ceil(log2(DIV)), counts 0..DIV-1, clears on every bit boundary and state change; no wrap beyond DIV-1.
REQ-017 Frame length from acceptance edge to IDLE: 10*DIV cycles (11*DIV with parity); first tx_out low edge one cycle after acceptance.
REQ-018 tx_enable_signal while tx_busy=1 SHALL be ignored (no queueing); tx_data changes during a frame SHALL NOT affect the frame.
REQ-019 Enable asserted in the tx_done_signal cycle SHALL be ignored; enable held high continuously yields frames separated by exactly one IDLE cycle.
REQ-020 tx_out SHALL be driven from a register (glitch-free).
REQ-021 DIV < 2 is illegal configuration; behaviour unspecified.

Reset
REQ-022 rst=0 at a rising clk edge SHALL force IDLE, tx_out=1, tx_busy=0, tx_done_signal=0, counters and shift register to 0.
REQ-023 Reset mid-frame SHALL abort the frame; tx_out returns high at the edge after reset sampled; no tx_done_signal issued.
REQ-024 First request SHALL be accepted in the first cycle with rst=1.

Configuration
REQ-025 Macro TX_UART_PARITY_EN defined: PARITY state inserted after DATA, tx_out = even parity (XOR of the 8 latched bits) for DIV cycles; frame 11*DIV cycles.
REQ-026 Macro TX_UART_PARITY_EN undefined: no PARITY state or parity logic; DATA goes directly to STOP; frame 10*DIV cycles.

Verification
REQ-027 Defaults, send 0x55 -> tx_out low 50 cycles, then 1,0,1,0,1,0,1,0 at 50 cycles each, high 50; tx_done_signal pulse at cycle 500 after acceptance.
REQ-028 Send 0xA5, change tx_data to 0xFF and pulse enable at cycle 200 -> sampled line decodes 0xA5, single done pulse, second request lost.
REQ-029 Enable held high, tx_data=0x00 -> two back-to-back frames with exactly one idle-high cycle between stop bit and next start bit.
REQ-030 rst=0 at cycle 230 of a 0x3C frame -> tx_out=1, tx_busy=0 next cycle; no done pulse; new 0x3C frame after release completes correctly.
REQ-031 TX_UART_PARITY_EN defined, send 0x07 then 0x03 -> parity bits 1 then 0; done at cycle 550 each.
REQ-032 BPS=115200, CLK_HZ=50000000 -> DIV=434, every bit period measured as 434 cycles.
